i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (slave) endpoint for the I2C master controller; answers one 7-bit address and exposes a DEPTH-byte register file to the bus.
- Oversamples SCL and SDA on the system clock, detects START and STOP, and decodes address, write and read phases.
- Write phase: the first data byte sets the register pointer; following bytes write the file with auto-increment.
- Read phase: returns file bytes with auto-increment. A local host port can also read and write the file.

Parameters:
- TGT_ADDR, 7'h50, 7-bit I2C address this target responds to.
- DEPTH, 16, register file depth in bytes; power of 2, range 2..256. AW = log2(DEPTH).
- FILTER_LEN, 3, number of consecutive equal synchronized samples needed to accept a new SCL or SDA level.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous reset, active-low.
- scl_pad_i  in  1  SCL line input.
- sda_pad_i  in  1  SDA line input.
- sda_pad_o  out  1  SDA output value; constant 0.
- sda_padoen_o  out  1  SDA output enable, active-low; 0 pulls SDA low.
- host_we_i  in  1  host write strobe.
- host_adr_i  in  AW  host register address.
- host_dat_i  in  8  host write data.
- host_dat_o  out  8  host read data, registered: reg[host_adr_i] one cycle later.
- reg_wr_o  out  1  one-cycle pulse when the I2C side writes a register.
- reg_adr_o  out  AW  address of the last I2C write.
- busy_o  out  1  high from an accepted address match until STOP or NACK-idle.

Behaviour:
Reset:
- wb_rst_i=0 sampled on a clock edge resets everything.
- sda_padoen_o=1, reg_wr_o=0, reg_adr_o=0, busy_o=0, host_dat_o=0.
- All registers =0, pointer=0, FSM=IDLE, filtered SCL/SDA=1.
- Reset mid-transfer releases SDA at the next clock edge.

Input conditioning:
- 2-flop synchronizer, then the FILTER_LEN agreement filter.
- Pad-to-internal latency = 2+FILTER_LEN cycles.
- Edges (scl_rise, scl_fall) are single-cycle pulses from the filtered levels.

Bus conditions:
- START = filtered SDA falls while filtered SCL=1. STOP = filtered SDA rises while SCL=1.
- START and STOP are recognized in every state and take priority over bit handling.
- START (including repeated START) -> ADDR, bit count=0, SDA released.
- STOP -> IDLE, busy_o=0.

Data timing:
- Data is sampled on scl_rise.
- SDA is driven or changed only in the cycle after scl_fall.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits MSB first. On the 8th scl_rise compare [7:1] with TGT_ADDR.
  - Match -> ADDR_ACK; latch R/W=bit0; busy_o=1.
  - Mismatch -> WAIT, SDA never driven.
- ADDR_ACK: on scl_fall drive SDA low (padoen=0). On the next scl_fall release SDA.
  - W -> WR_BYTE with first_byte=1.
  - R -> load shift=reg[ptr], drive MSB, RD_BYTE.
- WR_BYTE: shift 8 bits, then WR_ACK.
- WR_ACK: drive the ACK low for one SCL period as above. At the 9th scl_fall:
  - If first_byte: ptr=byte[AW-1:0], upper bits ignored, first_byte=0.
  - Else: reg[ptr]=byte, reg_wr_o pulse, reg_adr_o=ptr, ptr=ptr+1 mod DEPTH.
- RD_BYTE: on each scl_fall after the first, shift out the next bit.
  - padoen = bit (0 drives low, 1 releases).
  - After the 8th bit's scl_fall, release SDA -> RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): ptr++ mod DEPTH; at scl_fall load reg[ptr], drive MSB, RD_BYTE.
  - 1 (NACK): release SDA -> WAIT.
- WAIT: SDA released; ignore bits until START or STOP. busy_o=0 in WAIT.

Collisions and wrap:
- A host write and an I2C write to the same address in the same cycle: the I2C write wins.
- A host write to a different address in that cycle completes normally.
- Read-ahead uses the register value at load time; later writes do not alter a byte already in flight.
- Pointer wrap: DEPTH-1 +1 -> 0, for both reads and writes.

Test Plan:
- Write 0x50/W, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK low on all 9th clocks; reg[3]=0xA5, reg[4]=0x5A; two reg_wr_o pulses with reg_adr_o 3 then 4; busy_o=0 after STOP.
- Host writes reg[15]=0x11 and reg[0]=0x22; I2C write ptr 0x0F, repeated START, 0x50/R, read 2 bytes ACK then NACK, STOP -> SDA bytes 0x11 then 0x22 (wrap); SDA released after NACK.
- Address 0x51/W then 3 data bytes -> sda_padoen_o stays 1 throughout; no reg_wr_o; busy_o stays 0.
- 1-cycle SDA glitch while SCL high in IDLE (FILTER_LEN=3) -> no START detected, FSM stays IDLE.
- wb_rst_i=0 asserted while driving the address ACK -> sda_padoen_o=1 the next cycle; all registers 0; a new START then works normally.
- Host and I2C write reg[2] in the same cycle with host 0x33 and I2C 0xCC -> reg[2]=0xCC; host_dat_o for address 2 reads 0xCC one cycle later.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target endpoint: filters SCL/SDA, decodes START/STOP/address/data and
// exposes a DEPTH-byte register file to the bus and to a local host port.
module i2c_target_regs #(
   parameter logic [6:0] TGT_ADDR   = 7'h50,
   parameter int         DEPTH      = 16,
   parameter int         FILTER_LEN = 3,
   localparam int        AW         = $clog2(DEPTH)
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          scl_pad_i,
   input  logic          sda_pad_i,
   output logic          sda_pad_o,
   output logic          sda_padoen_o,
   input  logic          host_we_i,
   input  logic [AW-1:0] host_adr_i,
   input  logic [7:0]    host_dat_i,
   output logic [7:0]    host_dat_o,
   output logic          reg_wr_o,
   output logic [AW-1:0] reg_adr_o,
   output logic          busy_o
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT
   } state_t;

   state_t state, next_state;

   // Index 1 is SCL, index 0 is SDA.
   logic [1:0]    sync1, sync2, filt, filt_d;
   logic [CW-1:0] cnt [2];

   logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

   logic [7:0]    shift;
   logic [7:0]    byte_in;
   logic [3:0]    bit_cnt;
   logic          rw, first_byte, ack_on, sda_oe, busy, reg_wr;
   logic [AW-1:0] ptr, reg_adr;
   logic [7:0]    regs [DEPTH];

   logic sample_bit, drive_ack, end_ack, count_rd, next_bit, end_rd;
   logic take_ack, load_next, i2c_we;

   // A new level is accepted only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         sync1  <= '1;
         sync2  <= '1;
         filt   <= '1;
         filt_d <= '1;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1  <= {scl_pad_i, sda_pad_i};
         sync2  <= sync1;
         filt_d <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               filt[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign scl_f     = filt[1];
   assign sda_f     = filt[0];
   assign scl_rise  = filt[1] & ~filt_d[1];
   assign scl_fall  = ~filt[1] & filt_d[1];
   assign start_det = scl_f & filt_d[1] & filt_d[0] & ~sda_f;
   assign stop_det  = scl_f & filt_d[1] & ~filt_d[0] & sda_f;
   assign byte_in   = {shift[6:0], sda_f};

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) state <= S_IDLE;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (stop_det) begin
         next_state = S_IDLE;
      end else if (start_det) begin
         next_state = S_ADDR;
      end else begin
         case (state)
            S_ADDR:
               if (scl_rise && bit_cnt == 4'd7)
                  next_state = (byte_in[7:1] == TGT_ADDR) ? S_ADDR_ACK : S_WAIT;
            S_ADDR_ACK:
               if (scl_fall && ack_on) next_state = rw ? S_RD_BYTE : S_WR_BYTE;
            S_WR_BYTE:
               if (scl_rise && bit_cnt == 4'd7) next_state = S_WR_ACK;
            S_WR_ACK:
               if (scl_fall && ack_on) next_state = S_WR_BYTE;
            S_RD_BYTE:
               if (scl_fall && bit_cnt == 4'd8) next_state = S_RD_ACK;
            S_RD_ACK:
               if (scl_rise && sda_f)       next_state = S_WAIT;
               else if (scl_fall && ack_on) next_state = S_RD_BYTE;
            default: next_state = state;
         endcase
      end
   end

   // Per-state datapath strobes; bus conditions suppress all bit handling.
   always_comb begin
      sample_bit = 1'b0;
      drive_ack  = 1'b0;
      end_ack    = 1'b0;
      count_rd   = 1'b0;
      next_bit   = 1'b0;
      end_rd     = 1'b0;
      take_ack   = 1'b0;
      load_next  = 1'b0;
      if (!stop_det && !start_det) begin
         case (state)
            S_ADDR, S_WR_BYTE: sample_bit = scl_rise;
            S_ADDR_ACK, S_WR_ACK: begin
               drive_ack = scl_fall & ~ack_on;
               end_ack   = scl_fall & ack_on;
            end
            S_RD_BYTE: begin
               count_rd = scl_rise;
               next_bit = scl_fall && bit_cnt != 4'd8;
               end_rd   = scl_fall && bit_cnt == 4'd8;
            end
            S_RD_ACK: begin
               take_ack  = scl_rise;
               load_next = scl_fall & ack_on;
            end
            default: ;
         endcase
      end
      i2c_we = end_ack && state == S_WR_ACK && !first_byte;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         shift      <= '0;
         bit_cnt    <= '0;
         rw         <= 1'b0;
         first_byte <= 1'b0;
         ack_on     <= 1'b0;
         ptr        <= '0;
         sda_oe     <= 1'b1;
         busy       <= 1'b0;
         reg_wr     <= 1'b0;
         reg_adr    <= '0;
      end else begin
         reg_wr <= 1'b0;
         if (stop_det) begin
            sda_oe <= 1'b1;
            busy   <= 1'b0;
         end else if (start_det) begin
            sda_oe  <= 1'b1;
            bit_cnt <= '0;
         end else begin
            if (sample_bit) begin
               shift <= byte_in;
               if (bit_cnt == 4'd7) begin
                  bit_cnt <= '0;
                  ack_on  <= 1'b0;
                  if (state == S_ADDR) begin
                     if (byte_in[7:1] == TGT_ADDR) begin
                        rw   <= sda_f;
                        busy <= 1'b1;
                     end else begin
                        busy <= 1'b0;
                     end
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            if (drive_ack) begin
               sda_oe <= 1'b0;
               ack_on <= 1'b1;
            end
            if (end_ack) begin
               bit_cnt <= '0;
               if (state == S_ADDR_ACK) begin
                  first_byte <= 1'b1;
                  if (rw) begin
                     shift  <= regs[ptr];
                     sda_oe <= regs[ptr][7];
                  end else begin
                     sda_oe <= 1'b1;
                  end
               end else begin
                  sda_oe <= 1'b1;
                  if (first_byte) begin
                     ptr        <= shift[AW-1:0];
                     first_byte <= 1'b0;
                  end else begin
                     reg_wr  <= 1'b1;
                     reg_adr <= ptr;
                     ptr     <= ptr + 1'b1;
                  end
               end
            end
            if (count_rd) bit_cnt <= bit_cnt + 1'b1;
            if (next_bit) begin
               sda_oe <= shift[6];
               shift  <= {shift[6:0], 1'b0};
            end
            if (end_rd) begin
               sda_oe <= 1'b1;
               ack_on <= 1'b0;
            end
            if (take_ack) begin
               if (!sda_f) begin
                  ptr    <= ptr + 1'b1;
                  ack_on <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            if (load_next) begin
               shift   <= regs[ptr];
               sda_oe  <= regs[ptr][7];
               bit_cnt <= '0;
            end
         end
      end
   end

   // The I2C write is ordered after the host write so it wins on an address clash.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         host_dat_o <= '0;
      end else begin
         host_dat_o <= regs[host_adr_i];
         if (host_we_i) regs[host_adr_i] <= host_dat_i;
         if (i2c_we)    regs[ptr] <= shift;
      end
   end

   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = sda_oe;
   assign reg_wr_o     = reg_wr;
   assign reg_adr_o    = reg_adr;
   assign busy_o       = busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: bus master tasks post observations,
// a monitor pops them against queued hand-computed expectations.
module tb_i2c_target_regs;

   localparam int AW = 4;
   localparam int FL = 3;
   localparam int Q  = 8;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i = 1'b0;
   logic          scl_m = 1'b1;
   logic          sda_m = 1'b1;
   logic          sda_pad_o, sda_padoen_o;
   logic          host_we_i = 1'b0;
   logic [AW-1:0] host_adr_i = '0;
   logic [7:0]    host_dat_i = '0;
   logic [7:0]    host_dat_o;
   logic          reg_wr_o;
   logic [AW-1:0] reg_adr_o;
   logic          busy_o;
   wire           sda_line = sda_m & (sda_padoen_o | sda_pad_o);

   typedef struct {
      string      name;
      logic [7:0] val;
   } item_t;

   item_t         exp_q[$];
   item_t         obs_q[$];
   logic [AW-1:0] exp_wr_q[$];
   int            checks = 0;
   int            errors = 0;
   logic          collide = 1'b0;
   logic          glitch = 1'b0;
   logic          watch = 1'b0;
   logic          oe_low = 1'b0;
   logic          busy_hi = 1'b0;
   logic [7:0]    rd;
   logic          dummy;

   i2c_target_regs #(.TGT_ADDR(7'h50), .DEPTH(16), .FILTER_LEN(FL)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .scl_pad_i(scl_m), .sda_pad_i(sda_line),
      .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
      .host_we_i(host_we_i), .host_adr_i(host_adr_i), .host_dat_i(host_dat_i),
      .host_dat_o(host_dat_o), .reg_wr_o(reg_wr_o), .reg_adr_o(reg_adr_o),
      .busy_o(busy_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(negedge wb_clk_i) begin
      while (obs_q.size() > 0) begin
         item_t o;
         item_t e;
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: got %h, nothing expected", o.name, o.val);
         end else begin
            e = exp_q.pop_front();
            if (e.val !== o.val) begin
               errors++;
               $display("[TB] FAIL %s: got %h, expected %h (%s)", o.name, o.val, e.val, e.name);
            end
         end
      end
      if (reg_wr_o) begin
         checks++;
         if (exp_wr_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL reg_wr: unexpected pulse, reg_adr_o=%0d", reg_adr_o);
         end else if (exp_wr_q[0] !== reg_adr_o) begin
            errors++;
            $display("[TB] FAIL reg_wr: reg_adr_o=%0d, expected %0d", reg_adr_o, exp_wr_q[0]);
            void'(exp_wr_q.pop_front());
         end else begin
            void'(exp_wr_q.pop_front());
         end
      end
      if (watch) begin
         if (!sda_padoen_o) oe_low = 1'b1;
         if (busy_o)        busy_hi = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   task automatic expect_val(input string name, input logic [7:0] val);
      item_t it;
      it.name = name;
      it.val  = val;
      exp_q.push_back(it);
   endtask

   task automatic check_output(input string name, input logic [7:0] val);
      item_t it;
      it.name = name;
      it.val  = val;
      obs_q.push_back(it);
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
      host_adr_i = a;
      host_dat_i = d;
      host_we_i  = 1'b1;
      tick(1);
      host_we_i  = 1'b0;
   endtask

   task automatic host_read(input logic [AW-1:0] a, input string name, input logic [7:0] exp);
      expect_val(name, exp);
      host_adr_i = a;
      tick(1);
      check_output(name, host_dat_o);
   endtask

   // Every bus primitive starts and ends with SCL low except from idle.
   task automatic send_bit(input logic b, output logic seen);
      tick(Q); sda_m = b;
      tick(Q); scl_m = 1'b1;
      tick(Q); seen = sda_line;
      if (glitch) begin
         tick(2); scl_m = 1'b0;
         tick(1); scl_m = 1'b1;
         tick(Q - 3);
         glitch = 1'b0;
      end else begin
         tick(Q);
      end
      scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input string name, input logic exp_ack);
      logic s;
      expect_val(name, {7'b0, exp_ack});
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      send_bit(1'b1, s);
      check_output(name, {7'b0, s});
      if (collide) begin
         tick(FL + 2);
         host_we_i = 1'b1;
         tick(1);
         host_we_i = 1'b0;
         collide   = 1'b0;
      end
   endtask

   task automatic recv_byte(input logic nack, input string name, input logic [7:0] exp);
      logic s;
      logic [7:0] d;
      d = '0;
      expect_val(name, exp);
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, s);
         d = {d[6:0], s};
      end
      check_output(name, d);
      send_bit(nack, s);
   endtask

   task automatic bus_start();
      tick(Q); sda_m = 1'b1;
      tick(Q); scl_m = 1'b1;
      tick(Q); sda_m = 1'b0;
      tick(Q); scl_m = 1'b0;
   endtask

   task automatic bus_stop();
      tick(Q); sda_m = 1'b0;
      tick(Q); scl_m = 1'b1;
      tick(Q); sda_m = 1'b1;
      tick(Q);
   endtask

   task automatic post_now(input string name, input logic [7:0] exp, input logic [7:0] act);
      expect_val(name, exp);
      check_output(name, act);
   endtask

   initial begin
      $display("[TB] reset state");
      tick(3);
      post_now("rst_oe", 8'd1, {7'b0, sda_padoen_o});
      post_now("rst_busy", 8'd0, {7'b0, busy_o});
      post_now("rst_regwr", 8'd0, {7'b0, reg_wr_o});
      post_now("rst_hdat", 8'd0, host_dat_o);
      wb_rst_i = 1'b1;
      tick(4);

      $display("[TB] write ptr 3, data A5 5A");
      exp_wr_q.push_back(4'd3);
      exp_wr_q.push_back(4'd4);
      bus_start();
      send_byte(8'hA0, "t1_ack_adr", 1'b0);
      post_now("t1_busy", 8'd1, {7'b0, busy_o});
      send_byte(8'h03, "t1_ack_ptr", 1'b0);
      send_byte(8'hA5, "t1_ack_d0", 1'b0);
      send_byte(8'h5A, "t1_ack_d1", 1'b0);
      bus_stop();
      tick(2);
      post_now("t1_busy_stop", 8'd0, {7'b0, busy_o});
      host_read(4'd3, "t1_reg3", 8'hA5);
      host_read(4'd4, "t1_reg4", 8'h5A);

      $display("[TB] read with pointer wrap");
      host_write(4'd15, 8'h11);
      host_write(4'd0, 8'h22);
      bus_start();
      send_byte(8'hA0, "t2_ack_adrw", 1'b0);
      send_byte(8'h0F, "t2_ack_ptr", 1'b0);
      bus_start();
      send_byte(8'hA1, "t2_ack_adrr", 1'b0);
      recv_byte(1'b0, "t2_rd0", 8'h11);
      recv_byte(1'b1, "t2_rd1", 8'h22);
      tick(2);
      post_now("t2_nack_oe", 8'd1, {7'b0, sda_padoen_o});
      post_now("t2_nack_busy", 8'd0, {7'b0, busy_o});
      bus_stop();

      $display("[TB] address mismatch");
      oe_low  = 1'b0;
      busy_hi = 1'b0;
      watch   = 1'b1;
      bus_start();
      send_byte(8'hA2, "t3_ack_adr", 1'b1);
      send_byte(8'h12, "t3_ack_d0", 1'b1);
      send_byte(8'h34, "t3_ack_d1", 1'b1);
      send_byte(8'h56, "t3_ack_d2", 1'b1);
      bus_stop();
      tick(2);
      watch = 1'b0;
      post_now("t3_oe_low", 8'd0, {7'b0, oe_low});
      post_now("t3_busy_hi", 8'd0, {7'b0, busy_hi});

      $display("[TB] glitch rejection");
      tick(4);
      sda_m = 1'b0;
      tick(1);
      sda_m = 1'b1;
      tick(12);
      post_now("t4_busy", 8'd0, {7'b0, busy_o});
      post_now("t4_oe", 8'd1, {7'b0, sda_padoen_o});
      bus_start();
      glitch = 1'b1;
      send_byte(8'hA0, "t4_ack_adr", 1'b0);
      send_byte(8'h07, "t4_ack_ptr", 1'b0);
      bus_stop();

      $display("[TB] reset during address ACK");
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5, dummy);
      for (int i = 0; i < 40; i++) begin
         if (!sda_padoen_o) break;
         tick(1);
      end
      post_now("t5_ack_drv", 8'd0, {7'b0, sda_padoen_o});
      wb_rst_i = 1'b0;
      tick(1);
      post_now("t5_rst_oe", 8'd1, {7'b0, sda_padoen_o});
      post_now("t5_rst_adr", 8'd0, {4'b0, reg_adr_o});
      wb_rst_i = 1'b1;
      tick(2);
      host_read(4'd3, "t5_reg3", 8'h00);
      host_read(4'd4, "t5_reg4", 8'h00);
      host_read(4'd15, "t5_reg15", 8'h00);
      host_read(4'd0, "t5_reg0", 8'h00);
      exp_wr_q.push_back(4'd5);
      bus_start();
      send_byte(8'hA0, "t5_ack_adr", 1'b0);
      send_byte(8'h05, "t5_ack_ptr", 1'b0);
      send_byte(8'h77, "t5_ack_d0", 1'b0);
      bus_stop();
      host_read(4'd5, "t5_reg5", 8'h77);

      $display("[TB] host/I2C write collision");
      exp_wr_q.push_back(4'd2);
      bus_start();
      send_byte(8'hA0, "t6_ack_adr", 1'b0);
      send_byte(8'h02, "t6_ack_ptr", 1'b0);
      host_adr_i = 4'd2;
      host_dat_i = 8'h33;
      collide    = 1'b1;
      send_byte(8'hCC, "t6_ack_d0", 1'b0);
      bus_stop();
      host_read(4'd2, "t6_reg2", 8'hCC);

      tick(4);
      checks++;
      if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations and %0d writes left, expected 0",
                  exp_q.size(), exp_wr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
